// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step sequencer for the single-cycle RV32 core.
// Drives cpu_en, which qualifies the PC update, register-file write and
// data-memory write. The core is held in BOOT while instruction memory is
// preloaded. It can then be halted by a debugger, a PC breakpoint or an
// EBREAK, and single-stepped. The block also keeps cycle and
// retired-instruction counters.

module cpu_run_ctrl #(
   parameter int BOOT_CYCLES  = 16,
   parameter int START_HALTED = 0,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc,
   input  logic             inst_ebreak,
   input  logic             dbg_halt_req,
   input  logic             dbg_resume_req,
   input  logic             dbg_step_req,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic             cnt_clr,
   output logic             cpu_en,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   // The boot counter only needs to reach BOOT_CYCLES.
   localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES);

   localparam logic [1:0] CAUSE_STEP   = 2'd0;
   localparam logic [1:0] CAUSE_DEBUG  = 2'd1;
   localparam logic [1:0] CAUSE_BP     = 2'd2;
   localparam logic [1:0] CAUSE_EBREAK = 2'd3;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   state_t              state;
   logic [BOOT_W-1:0]   boot_cnt;
   logic                skip;

   logic                bp_hit;
   logic                ebreak_hit;
   logic                run_stop;
   logic [1:0]          stop_cause;

   // Stop detection while running. The skip flag masks the breakpoint and
   // EBREAK so that a resume or step from one of them does not re-halt at
   // once. A debugger halt request is never masked.
   always_comb begin
      bp_hit     = bp_en & (pc == bp_addr) & ~skip;
      ebreak_hit = inst_ebreak & ~skip;
      run_stop   = dbg_halt_req | bp_hit | ebreak_hit;
      stop_cause = CAUSE_EBREAK;
      if (dbg_halt_req) begin
         stop_cause = CAUSE_DEBUG;
      end else if (bp_hit) begin
         stop_cause = CAUSE_BP;
      end
   end

   // Commit qualifier. This is combinational from pc and inst_ebreak, so a
   // stopping instruction never commits.
   always_comb begin
      cpu_en = 1'b0;
      case (state)
         ST_RUN:  cpu_en = ~run_stop;
         ST_STEP: cpu_en = 1'b1;
         default: cpu_en = 1'b0;
      endcase
   end

   assign halted = (state == ST_HALT);

   // Sequencer: BOOT preload window, free run, halt and single step,
   // together with the skip flag and the latched halt cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BOOT;
         boot_cnt   <= '0;
         skip       <= 1'b0;
         halt_cause <= CAUSE_STEP;
      end else begin
         if (cpu_en) begin
            skip <= 1'b0;
         end
         case (state)
            ST_BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  if (START_HALTED != 0) begin
                     state      <= ST_HALT;
                     halt_cause <= CAUSE_DEBUG;
                  end else begin
                     state <= ST_RUN;
                  end
               end else begin
                  boot_cnt <= boot_cnt + BOOT_W'(1);
               end
            end
            ST_RUN: begin
               if (run_stop) begin
                  state      <= ST_HALT;
                  halt_cause <= stop_cause;
               end
            end
            ST_HALT: begin
               if (dbg_step_req) begin
                  state <= ST_STEP;
                  skip  <= 1'b1;
               end else if (dbg_resume_req) begin
                  state <= ST_RUN;
                  skip  <= 1'b1;
               end
            end
            ST_STEP: begin
               state      <= ST_HALT;
               halt_cause <= CAUSE_STEP;
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   // Performance counters. A clear takes priority over counting, and both
   // counters wrap naturally at their width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != ST_BOOT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
         if (cpu_en) begin
            instret_cnt <= instret_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. A reference model tracks boot, halt and step
// behaviour and is compared against the DUT on every cycle. Directed
// literal checks pin down the key points of each scenario.

module tb_cpu_run_ctrl;

   localparam int CNT_MOD = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc = '0;
   logic        inst_ebreak = 1'b0;
   logic        dbg_halt_req = 1'b0;
   logic        dbg_resume_req = 1'b0;
   logic        dbg_step_req = 1'b0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = '0;
   logic        cnt_clr = 1'b0;

   logic        cpu_en;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [3:0]  cycle_cnt;
   logic [3:0]  instret_cnt;

   logic        cpu_en2;
   logic        halted2;
   logic [1:0]  halt_cause2;
   logic [7:0]  cycle_cnt2;
   logic [7:0]  instret_cnt2;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   bit m_in_boot = 1'b1;
   int m_boot_seen = 0;
   bit m_halted = 1'b0;
   bit m_stepping = 1'b0;
   bit m_skip = 1'b0;
   int m_cause = 0;
   int m_cyc = 0;
   int m_ret = 0;

   cpu_run_ctrl #(.BOOT_CYCLES(4), .START_HALTED(0), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .inst_ebreak(inst_ebreak),
      .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
      .dbg_step_req(dbg_step_req), .bp_en(bp_en), .bp_addr(bp_addr),
      .cnt_clr(cnt_clr), .cpu_en(cpu_en), .halted(halted),
      .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   cpu_run_ctrl #(.BOOT_CYCLES(0), .START_HALTED(1), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .pc(pc), .inst_ebreak(inst_ebreak),
      .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
      .dbg_step_req(dbg_step_req), .bp_en(bp_en), .bp_addr(bp_addr),
      .cnt_clr(cnt_clr), .cpu_en(cpu_en2), .halted(halted2),
      .halt_cause(halt_cause2), .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic bit modelRunning();
      return !m_in_boot && !m_halted && !m_stepping;
   endfunction

   function automatic bit modelBpHit();
      return bp_en && (pc == bp_addr) && !m_skip;
   endfunction

   function automatic bit modelEbreakHit();
      return inst_ebreak && !m_skip;
   endfunction

   // The instruction commits only while stepping, or while running with no reason to stop.
   function automatic bit modelCommit();
      if (m_stepping) return 1'b1;
      if (!modelRunning()) return 1'b0;
      return !(dbg_halt_req || modelBpHit() || modelEbreakHit());
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] p, input logic eb, input logic h,
                                input logic r, input logic s);
      pc = p;
      inst_ebreak = eb;
      dbg_halt_req = h;
      dbg_resume_req = r;
      dbg_step_req = s;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model update on each clock edge, with asynchronous reset.
   always @(posedge clk or negedge rst_n) begin : model_blk
      bit en;
      int cause;
      if (!rst_n) begin
         m_in_boot = 1'b1;
         m_boot_seen = 0;
         m_halted = 1'b0;
         m_stepping = 1'b0;
         m_skip = 1'b0;
         m_cause = 0;
         m_cyc = 0;
         m_ret = 0;
      end else begin
         en = modelCommit();
         cause = dbg_halt_req ? 1 : (modelBpHit() ? 2 : 3);
         if (cnt_clr) begin
            m_cyc = 0;
            m_ret = 0;
         end else begin
            if (!m_in_boot) m_cyc = (m_cyc + 1) % CNT_MOD;
            if (en) m_ret = (m_ret + 1) % CNT_MOD;
         end
         if (en) m_skip = 1'b0;
         if (m_in_boot) begin
            if (m_boot_seen == 4) m_in_boot = 1'b0;
            else m_boot_seen++;
         end else if (m_halted) begin
            if (dbg_step_req || dbg_resume_req) begin
               m_halted = 1'b0;
               m_stepping = dbg_step_req;
               m_skip = 1'b1;
            end
         end else if (m_stepping) begin
            m_stepping = 1'b0;
            m_halted = 1'b1;
            m_cause = 0;
         end else if (!en) begin
            m_halted = 1'b1;
            m_cause = cause;
         end
      end
   end

   // Compare the DUT against the model midway through every cycle.
   always @(negedge clk) begin
      checkOutput("cyc_cpu_en", 32'(cpu_en), 32'(modelCommit()));
      checkOutput("cyc_halted", 32'(halted), 32'(m_halted));
      checkOutput("cyc_cycle_cnt", 32'(cycle_cnt), m_cyc);
      checkOutput("cyc_instret_cnt", 32'(instret_cnt), m_ret);
      if (m_halted) checkOutput("cyc_halt_cause", 32'(halt_cause), m_cause);
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      rst_n = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("rst_cpu_en", 32'(cpu_en), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_cycle", 32'(cycle_cnt), 32'd0);
      checkOutput("rst_instret", 32'(instret_cnt), 32'd0);

      // Boot window: 5 edges with cpu_en low, then run.
      rst_n = 1'b1;
      applyStimulus(32'h0, 0, 0, 0, 0);
      nextCycle();
      checkOutput("boot0_halted2", 32'(halted2), 32'd1);
      checkOutput("boot0_cause2", 32'(halt_cause2), 32'd1);
      checkOutput("boot0_cpu_en2", 32'(cpu_en2), 32'd0);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("boot4_cpu_en", 32'(cpu_en), 32'd0);
      checkOutput("boot4_cycle", 32'(cycle_cnt), 32'd0);
      nextCycle();
      checkOutput("boot_run_cpu_en", 32'(cpu_en), 32'd1);
      checkOutput("boot_run_cycle", 32'(cycle_cnt), 32'd0);
      checkOutput("boot_cycle2", 32'(cycle_cnt2), 32'd4);

      // Breakpoint at 0x10.
      bp_en = 1'b1;
      bp_addr = 32'h10;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'(i * 4), 0, 0, 0, 0);
         nextCycle();
      end
      applyStimulus(32'h10, 0, 0, 0, 0);
      checkOutput("bp_cpu_en", 32'(cpu_en), 32'd0);
      nextCycle();
      checkOutput("bp_halted", 32'(halted), 32'd1);
      checkOutput("bp_cause", 32'(halt_cause), 32'd2);
      checkOutput("bp_instret", 32'(instret_cnt), 32'd4);
      checkOutput("bp_cycle", 32'(cycle_cnt), 32'd5);

      // Single step over the breakpoint.
      applyStimulus(32'h10, 0, 0, 0, 1);
      checkOutput("step_req_cpu_en", 32'(cpu_en), 32'd0);
      nextCycle();
      applyStimulus(32'h10, 0, 0, 0, 0);
      checkOutput("step_cpu_en", 32'(cpu_en), 32'd1);
      checkOutput("step_halted", 32'(halted), 32'd0);
      nextCycle();
      checkOutput("step_done_halted", 32'(halted), 32'd1);
      checkOutput("step_done_cause", 32'(halt_cause), 32'd0);
      checkOutput("step_done_instret", 32'(instret_cnt), 32'd5);

      // EBREAK halt, then resume executes it once.
      applyStimulus(32'h14, 0, 0, 1, 0);
      nextCycle();
      applyStimulus(32'h14, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(32'h18, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(32'h20, 1, 0, 0, 0);
      checkOutput("ebk_cpu_en", 32'(cpu_en), 32'd0);
      nextCycle();
      checkOutput("ebk_cause", 32'(halt_cause), 32'd3);
      checkOutput("ebk_instret", 32'(instret_cnt), 32'd7);
      applyStimulus(32'h20, 1, 0, 1, 0);
      nextCycle();
      applyStimulus(32'h20, 1, 0, 0, 0);
      checkOutput("ebk_resume_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();
      applyStimulus(32'h24, 0, 0, 0, 0);
      checkOutput("ebk_after_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();
      checkOutput("ebk_after_instret", 32'(instret_cnt), 32'd9);

      // Resume and step in the same cycle: step wins.
      applyStimulus(32'h28, 0, 1, 0, 0);
      nextCycle();
      checkOutput("dbg_cause", 32'(halt_cause), 32'd1);
      applyStimulus(32'h28, 0, 0, 1, 1);
      nextCycle();
      applyStimulus(32'h28, 0, 0, 0, 0);
      checkOutput("both_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();
      checkOutput("both_halted", 32'(halted), 32'd1);
      checkOutput("both_cause", 32'(halt_cause), 32'd0);
      checkOutput("both_instret", 32'(instret_cnt), 32'd10);

      // Debug halt request beats a coincident breakpoint; halt request during STEP ignored.
      applyStimulus(32'h2c, 0, 0, 1, 0);
      nextCycle();
      applyStimulus(32'h2c, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(32'h10, 0, 1, 0, 0);
      checkOutput("prio_cpu_en", 32'(cpu_en), 32'd0);
      nextCycle();
      checkOutput("prio_cause", 32'(halt_cause), 32'd1);
      applyStimulus(32'h10, 0, 0, 0, 1);
      nextCycle();
      applyStimulus(32'h10, 0, 1, 0, 0);
      checkOutput("step_hreq_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();
      checkOutput("step_hreq_cause", 32'(halt_cause), 32'd0);
      checkOutput("step_hreq_instret", 32'(instret_cnt), 32'd12);

      // Counter clear on resume, 17 commits wrap the 4-bit counters to 1.
      bp_en = 1'b0;
      cnt_clr = 1'b1;
      applyStimulus(32'h40, 0, 0, 1, 0);
      nextCycle();
      cnt_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(32'h40 + 32'(i * 4), 0, 0, 0, 0);
         nextCycle();
      end
      checkOutput("wrap_instret", 32'(instret_cnt), 32'd1);
      checkOutput("wrap_cycle", 32'(cycle_cnt), 32'd1);
      cnt_clr = 1'b1;
      applyStimulus(32'h100, 0, 0, 0, 0);
      checkOutput("clr_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();
      cnt_clr = 1'b0;
      checkOutput("clr_instret", 32'(instret_cnt), 32'd0);
      checkOutput("clr_cycle", 32'(cycle_cnt), 32'd0);

      // Reset asserted during STEP.
      applyStimulus(32'h104, 0, 1, 0, 0);
      nextCycle();
      applyStimulus(32'h104, 0, 0, 0, 1);
      nextCycle();
      applyStimulus(32'h104, 0, 0, 0, 0);
      checkOutput("pre_rst_cpu_en", 32'(cpu_en), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
      checkOutput("mid_rst_halted", 32'(halted), 32'd0);
      checkOutput("mid_rst_cycle", 32'(cycle_cnt), 32'd0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(32'h0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) nextCycle();
      checkOutput("reboot4_cpu_en", 32'(cpu_en), 32'd0);
      nextCycle();
      checkOutput("reboot_run_cpu_en", 32'(cpu_en), 32'd1);
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt/step sequencer for the single-cycle RV32 core. It generates cpu_en, which qualifies the PC update, register-file write enable and data-memory write, so the core can be held after boot, halted by a debugger, a PC breakpoint or an EBREAK, and single-stepped. It also keeps cycle and retired-instruction counters. It sits between the top-level debug interface and the PC / reg_file / data_mem write qualifiers.

Parameters:
BOOT_CYCLES, 16, cycles cpu_en is held low after reset release (instruction memory preload window); 0 is legal
START_HALTED, 0, 1 = enter HALT instead of RUN after BOOT
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
pc  input  32  current PC from the PC register
inst_ebreak  input  1  current instruction decodes as EBREAK (32'h00100073)
dbg_halt_req  input  1  one-cycle pulse: request halt
dbg_resume_req  input  1  one-cycle pulse: resume free run
dbg_step_req  input  1  one-cycle pulse: execute exactly one instruction
bp_en  input  1  PC breakpoint enable
bp_addr  input  32  breakpoint address
cnt_clr  input  1  synchronous clear of both counters
cpu_en  output  1  1 = current instruction commits this cycle
halted  output  1  core is in HALT
halt_cause  output  2  0 step done, 1 debug request, 2 breakpoint, 3 EBREAK; valid while halted=1
cycle_cnt  output  CNT_W  cycles spent outside BOOT
instret_cnt  output  CNT_W  instructions committed

Behaviour:
- Reset is asynchronous. On reset: state=BOOT, boot counter=0, skip=0, halt_cause=0, both counters=0, halted=0, cpu_en=0.
- States are BOOT, RUN, HALT and STEP. The state, boot counter, skip flag, halt_cause and counters are registered.
- halted = (state==HALT).
- cpu_en is combinational:
  - BOOT and HALT: 0.
  - STEP: 1.
  - RUN: 1 unless a stop condition exists this cycle.
- Stop conditions in RUN, in priority order:
  - dbg_halt_req gives cause 1.
  - bp_hit = bp_en & (pc==bp_addr) & ~skip gives cause 2.
  - inst_ebreak & ~skip gives cause 3.
  - On any stop condition: cpu_en=0 in that cycle, so the instruction does not commit. Next state is HALT, and halt_cause is loaded with the winning cause.
- BOOT:
  - The boot counter increments each cycle.
  - When the counter equals BOOT_CYCLES, the next state is RUN, or HALT with cause 1 if START_HALTED=1.
  - With BOOT_CYCLES=0, the block leaves BOOT on the first clock edge after rst_n deasserts.
  - Debug requests are ignored in BOOT.
- HALT:
  - dbg_step_req moves to STEP. dbg_resume_req moves to RUN.
  - If both arrive in the same cycle, step wins.
  - Leaving HALT sets skip=1. dbg_halt_req in HALT is ignored.
- skip flag:
  - Cleared on the first cycle in which cpu_en=1.
  - While set, it masks bp_hit and inst_ebreak. This prevents an immediate re-halt on the same breakpoint or EBREAK.
  - dbg_halt_req is never masked.
  - Note: resuming on an EBREAK executes it once as a NOP-commit. The debugger advances the PC if a different behaviour is required.
- STEP:
  - Lasts exactly one cycle with cpu_en=1, then goes to HALT with cause 0.
  - dbg_halt_req, dbg_resume_req and dbg_step_req during STEP are ignored.
- Counters:
  - cycle_cnt increments every cycle with state!=BOOT.
  - instret_cnt increments every cycle with cpu_en=1.
  - Both wrap modulo 2^CNT_W.
  - cnt_clr forces both to 0 on the next edge and takes priority over increment.
- Combinational path pc/inst_ebreak to cpu_en is by design. The timing budget is a 32-bit compare plus 3 gate levels.
- Reset asserted mid-operation, in any state, returns to BOOT immediately. No pending request survives reset.

Test Plan:
1. BOOT_CYCLES=4, START_HALTED=0: release reset → cpu_en=0 for exactly the first 5 edges of BOOT (count 0..4), then 1. cycle_cnt=0 through BOOT, then increments by 1 per cycle.
2. RUN, bp_en=1, bp_addr=32'h10, PC sequence 0,4,8,C,10 → cpu_en=0 when pc=10. Next cycle halted=1, halt_cause=2, and instret_cnt=4.
3. From step 2, pulse dbg_step_req → one cycle STEP with cpu_en=1 at pc=10 (breakpoint skipped). Then halted=1, halt_cause=0, instret_cnt=5.
4. RUN with inst_ebreak=1 at pc=20 → halt cause 3. Resume → the EBREAK commits once, then RUN continues. Same-cycle dbg_resume_req+dbg_step_req in HALT → STEP.
5. dbg_halt_req coincident with bp_hit → halt_cause=1. dbg_halt_req during STEP → ignored, halt_cause=0.
6. CNT_W=4: run 17 committed instructions → instret_cnt wraps to 1. cnt_clr with cpu_en=1 → 0 next cycle. Assert rst_n=0 during STEP → cpu_en=0 immediately and state=BOOT.
